// File: rtl/register_file.sv
// RV32I architectural register file: x0 reads as zero, two registered read ports
// captured on read_enable. Optional write-through on same-edge hazards: REGFILE_BYPASS_EN.
module register_file #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    localparam int IDX_W    = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             read_enable,
    input  logic [IDX_W-1:0] rs1,
    input  logic [IDX_W-1:0] rs2,
    input  logic             write_enable,
    input  logic [IDX_W-1:0] rd,
    input  logic [XLEN-1:0]  write_value,
    output logic [XLEN-1:0]  rs1_value,
    output logic [XLEN-1:0]  rs2_value,
    output logic             rs_valid
);

    logic [XLEN-1:0] regs [REG_COUNT];
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic            wr_hit;

    assign wr_hit = write_enable && (rd != '0);

    // Entry 0 is reset and never written, so it stays constant zero and is pruned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[rd] <= write_value;
        end
    end

    function automatic logic [XLEN-1:0] read_reg(input logic [IDX_W-1:0] idx);
        logic [XLEN-1:0] d;
        d = '0;
        if (idx != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (rd == idx)) d = write_value;
            else                       d = regs[idx];
`else
            d = regs[idx];
`endif
        end
        return d;
    endfunction

    always_comb begin
        rd1_data = read_reg(rs1);
        rd2_data = read_reg(rs2);
    end

    // Operands only move on read_enable; a write alone invalidates them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs1_value <= '0;
            rs2_value <= '0;
            rs_valid  <= 1'b0;
        end else if (read_enable) begin
            rs1_value <= rd1_data;
            rs2_value <= rd2_data;
            rs_valid  <= 1'b1;
        end else if (write_enable) begin
            rs_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected operands are pushed when a read is
// driven and popped when the registered outputs appear one cycle later.
module tb_register_file;

    logic        clk;
    logic        reset_n;
    logic        read_enable;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        write_enable;
    logic [4:0]  rd;
    logic [31:0] write_value;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs_valid;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [32];
    logic        exp_v;
    int          n_pass;
    int          n_total;

    register_file #(.XLEN(32), .REG_COUNT(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read_enable  (read_enable),
        .rs1          (rs1),
        .rs2          (rs2),
        .write_enable (write_enable),
        .rd           (rd),
        .write_value  (write_value),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value),
        .rs_valid     (rs_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdl_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] d, input logic [31:0] wv);
        if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && d == idx) return wv;
`endif
        return mdl[idx];
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        exp_v = 1'b0;
    endfunction

    // Drive one cycle of strobes (called 1ns after a rising edge), then settle 1ns past the next edge.
    task automatic step(input logic re, input logic [4:0] a1, input logic [4:0] a2,
                        input logic we, input logic [4:0] d, input logic [31:0] wv);
        exp_t e;
        read_enable  = re;
        rs1          = a1;
        rs2          = a2;
        write_enable = we;
        rd           = d;
        write_value  = wv;
        if (re) begin
            e.r1 = mdl_read(a1, we, d, wv);
            e.r2 = mdl_read(a2, we, d, wv);
            sbq.push_back(e);
        end
        if (we && d != 5'd0) mdl[d] = wv;
        if (re)      exp_v = 1'b1;
        else if (we) exp_v = 1'b0;
        @(posedge clk);
        #1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        step(0, 0, 0, 1, 5'd5, 32'h0000_0ABC);
        step(1, 5'd5, 5'd5, 0, 0, 0);
        e = sbq.pop_front();
        n_total++;
        if (rs1_value !== 32'h0000_0ABC) $display("FAIL pre_reset_read got %h want %h", rs1_value, 32'h0000_0ABC);
        else n_pass++;
        #3 reset_n = 1'b0;
        #1;
        n_total++;
        if (rs1_value !== 32'h0 || rs2_value !== 32'h0 || rs_valid !== 1'b0)
            $display("FAIL async_reset got %h %h %b want 0 0 0", rs1_value, rs2_value, rs_valid);
        else n_pass++;
        mdl_clear();
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(1, 5'd5, 5'd0, 0, 0, 0);
        e = sbq.pop_front();
        n_total++;
        if (rs1_value !== e.r1 || e.r1 !== 32'h0) $display("FAIL reset_x5 got %h want %h", rs1_value, 32'h0);
        else n_pass++;
    endtask

    task automatic test_write_read();
        exp_t e;
        step(0, 0, 0, 1, 5'd7, 32'hDEAD_BEEF);
        step(1, 5'd7, 5'd0, 0, 0, 0);
        e = sbq.pop_front();
        n_total += 3;
        if (rs1_value !== e.r1) $display("FAIL wr_rs1 got %h want %h", rs1_value, e.r1); else n_pass++;
        if (rs2_value !== e.r2) $display("FAIL wr_rs2 got %h want %h", rs2_value, e.r2); else n_pass++;
        if (rs_valid !== 1'b1)  $display("FAIL wr_valid got %b want 1", rs_valid); else n_pass++;
    endtask

    task automatic test_x0();
        exp_t e;
        step(0, 0, 0, 1, 5'd0, 32'h1234_5678);
        step(1, 5'd0, 5'd7, 0, 0, 0);
        e = sbq.pop_front();
        n_total += 2;
        if (rs1_value !== 32'h0) $display("FAIL x0_read got %h want %h", rs1_value, 32'h0); else n_pass++;
        if (rs2_value !== e.r2)  $display("FAIL x0_other got %h want %h", rs2_value, e.r2); else n_pass++;
    endtask

    task automatic test_same_edge();
        exp_t e;
        logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'hA5A5_A5A5;
`else
        want = 32'h0000_0001;
`endif
        step(0, 0, 0, 1, 5'd3, 32'h0000_0001);
        step(1, 5'd3, 5'd3, 1, 5'd3, 32'hA5A5_A5A5);
        e = sbq.pop_front();
        n_total += 3;
        if (rs1_value !== want || e.r1 !== want) $display("FAIL same_rs1 got %h want %h", rs1_value, want); else n_pass++;
        if (rs2_value !== want) $display("FAIL same_rs2 got %h want %h", rs2_value, want); else n_pass++;
        if (rs_valid !== 1'b1)  $display("FAIL same_valid got %b want 1", rs_valid); else n_pass++;
        step(1, 5'd3, 5'd0, 0, 0, 0);
        e = sbq.pop_front();
        n_total++;
        if (rs1_value !== 32'hA5A5_A5A5) $display("FAIL same_after got %h want %h", rs1_value, 32'hA5A5_A5A5); else n_pass++;
    endtask

    task automatic test_boundary();
        exp_t e;
        logic [31:0] h1, h2;
        step(0, 0, 0, 1, 5'd31, 32'hFFFF_FFFF);
        step(0, 0, 0, 1, 5'd1, 32'h8000_0000);
        step(1, 5'd31, 5'd1, 0, 0, 0);
        e = sbq.pop_front();
        n_total += 2;
        if (rs1_value !== 32'hFFFF_FFFF) $display("FAIL x31 got %h want %h", rs1_value, 32'hFFFF_FFFF); else n_pass++;
        if (rs2_value !== 32'h8000_0000) $display("FAIL x1 got %h want %h", rs2_value, 32'h8000_0000); else n_pass++;
        h1 = rs1_value;
        h2 = rs2_value;
        step(0, 5'd4, 5'd9, 0, 0, 0);
        n_total += 2;
        if (rs1_value !== 32'hFFFF_FFFF || rs2_value !== 32'h8000_0000)
            $display("FAIL hold got %h %h want %h %h", rs1_value, rs2_value, 32'hFFFF_FFFF, 32'h8000_0000);
        else n_pass++;
        if (rs_valid !== 1'b1) $display("FAIL hold_valid got %b want 1", rs_valid); else n_pass++;
        step(0, 0, 0, 1, 5'd2, 32'h5555_5555);
        n_total += 2;
        if (rs_valid !== 1'b0) $display("FAIL valid_fall got %b want 0", rs_valid); else n_pass++;
        if (rs1_value !== h1 || rs2_value !== h2)
            $display("FAIL write_hold got %h %h want %h %h", rs1_value, rs2_value, h1, h2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] l1, l2;
        logic        re, we;
        l1 = rs1_value;
        l2 = rs2_value;
        for (int i = 0; i < 40; i++) begin
            re = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 2) != 0);
            step(re, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), we,
                 5'($urandom_range(0, 7)), $urandom());
            if (re) begin
                e  = sbq.pop_front();
                l1 = e.r1;
                l2 = e.r2;
            end
            n_total += 3;
            if (rs1_value !== l1) $display("FAIL b2b_rs1[%0d] got %h want %h", i, rs1_value, l1); else n_pass++;
            if (rs2_value !== l2) $display("FAIL b2b_rs2[%0d] got %h want %h", i, rs2_value, l2); else n_pass++;
            if (rs_valid !== exp_v) $display("FAIL b2b_valid[%0d] got %b want %b", i, rs_valid, exp_v); else n_pass++;
        end
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset_n      = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        rs1          = '0;
        rs2          = '0;
        rd           = '0;
        write_value  = '0;
        mdl_clear();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (rs1_value !== 32'h0 || rs2_value !== 32'h0 || rs_valid !== 1'b0)
            $display("FAIL reset_state got %h %h %b want 0 0 0", rs1_value, rs2_value, rs_valid);
        else n_pass++;
        reset_n = 1'b1;
        test_reset();
        test_write_read();
        test_x0();
        test_same_edge();
        test_boundary();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
